branch_resolve_unit: RTL and testbench

//   EX-stage consumer of the ALU flags bus {v,c,n,z}. Evaluates branch conditions from the flags, compares
//   the outcome against the fetch-time prediction and issues a registered redirect/flush to fetch.

---
 rtl/branch_resolve_unit.sv | 116 +++++++++++
 tb/tb_branch_resolve_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: condition evaluation, registered redirect/flush,
// 2-bit BHT owned here and trained on resolved conditional branches.
module branch_resolve_unit #(
    parameter int BHT_ENTRIES = 64,
    parameter int IDX_W       = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_if,
    output logic        pred_taken_if,
    input  logic        valid_ex,
    input  logic        stall_ex,
    input  logic        is_branch,
    input  logic        is_jump,
    input  logic [2:0]  funct3,
    input  logic [3:0]  flags,
    input  logic [31:0] pc_ex,
    input  logic [31:0] target_ex,
    input  logic        pred_taken_ex,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [1:0]       bht_d [BHT_ENTRIES];
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [31:0]      br_count_q, br_count_d;
    logic [31:0]      mispred_count_q, mispred_count_d;

    logic             flag_v, flag_c, flag_n, flag_z;
    logic             resolve, cond, known_f3, br_res, jmp_res, taken, mispred;
    logic [IDX_W-1:0] idx_if, idx_ex;
    logic             unused_pc_bits;

    assign {flag_v, flag_c, flag_n, flag_z} = flags;
    assign idx_if = pc_if[IDX_W+1:2];
    assign idx_ex = pc_ex[IDX_W+1:2];
    assign unused_pc_bits = ^{pc_if[31:IDX_W+2], pc_if[1:0]};

    // No bypass: fetch sees the pre-update counter on a same-index collision.
    assign pred_taken_if = bht_q[idx_if][1];

    always_comb begin
        cond     = 1'b0;
        known_f3 = 1'b1;
        case (funct3)
            3'b000:  cond = flag_z;
            3'b001:  cond = ~flag_z;
            3'b100:  cond = flag_n ^ flag_v;
            3'b101:  cond = ~(flag_n ^ flag_v);
            3'b110:  cond = ~flag_c;
            3'b111:  cond = flag_c;
            default: known_f3 = 1'b0;
        endcase
    end

    // A live flush means EX now holds a wrong-path instruction.
    assign resolve = valid_ex & ~stall_ex & ~redirect_valid_q;
    assign jmp_res = resolve & is_jump;
    assign br_res  = resolve & is_branch & ~is_jump & known_f3;
    assign taken   = cond;
    assign mispred = jmp_res | (br_res & (taken ^ pred_taken_ex));

    always_comb begin
        redirect_valid_d = mispred;
        redirect_pc_d    = redirect_pc_q;
        br_count_d       = br_count_q;
        mispred_count_d  = mispred_count_q;
        bht_d            = bht_q;
        if (mispred) begin
            if (jmp_res || taken)
                redirect_pc_d = target_ex;
            else
                redirect_pc_d = pc_ex + 32'd4;
            if (mispred_count_q != 32'hFFFF_FFFF)
                mispred_count_d = mispred_count_q + 32'd1;
        end
        if (br_res) begin
            if (br_count_q != 32'hFFFF_FFFF)
                br_count_d = br_count_q + 32'd1;
            if (taken && bht_q[idx_ex] != 2'b11)
                bht_d[idx_ex] = bht_q[idx_ex] + 2'b01;
            else if (!taken && bht_q[idx_ex] != 2'b00)
                bht_d[idx_ex] = bht_q[idx_ex] - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            br_count_q       <= 32'd0;
            mispred_count_q  <= 32'd0;
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht_q[i] <= 2'b01;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            br_count_q       <= br_count_d;
            mispred_count_q  <= mispred_count_d;
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht_q[i] <= bht_d[i];
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign flush          = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign br_count       = br_count_q;
    assign mispred_count  = mispred_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: redirects, BHT training,
// counters, stall handling and asynchronous reset during a flush.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_if;
    logic        pred_taken_if;
    logic        valid_ex, stall_ex, is_branch, is_jump;
    logic [2:0]  funct3;
    logic [3:0]  flags;
    logic [31:0] pc_ex, target_ex;
    logic        pred_taken_ex;
    logic        redirect_valid, flush;
    logic [31:0] redirect_pc, br_count, mispred_count;

    int errors = 0;
    int checks = 0;

    branch_resolve_unit dut (
        .clk(clk), .reset_n(reset_n), .pc_if(pc_if),
        .pred_taken_if(pred_taken_if), .valid_ex(valid_ex),
        .stall_ex(stall_ex), .is_branch(is_branch), .is_jump(is_jump),
        .funct3(funct3), .flags(flags), .pc_ex(pc_ex),
        .target_ex(target_ex), .pred_taken_ex(pred_taken_ex),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ent(input string tag, input int idx, input logic [1:0] exp);
        chk(tag, {30'd0, dut.bht_q[idx]}, {30'd0, exp});
    endtask

    task automatic present(input logic br, input logic jmp,
                           input logic [2:0] f3, input logic [3:0] fl,
                           input logic [31:0] pc, input logic [31:0] tgt,
                           input logic pred);
        valid_ex = 1'b1; is_branch = br; is_jump = jmp; funct3 = f3;
        flags = fl; pc_ex = pc; target_ex = tgt; pred_taken_ex = pred;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic exec(input logic br, input logic jmp,
                        input logic [2:0] f3, input logic [3:0] fl,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pred);
        present(br, jmp, f3, fl, pc, tgt, pred);
        tick();
        valid_ex = 1'b0;
    endtask

    task automatic idle;
        valid_ex = 1'b0;
        tick();
    endtask

    initial begin
        reset_n = 1'b0; pc_if = 32'h0; valid_ex = 1'b0; stall_ex = 1'b0;
        is_branch = 1'b0; is_jump = 1'b0; funct3 = 3'b0; flags = 4'b0;
        pc_ex = 32'h0; target_ex = 32'h0; pred_taken_ex = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_br", br_count, 32'd0);
        chk("rst_mis", mispred_count, 32'd0);
        ent("rst_bht0", 0, 2'b01);
        @(negedge clk);
        reset_n = 1'b1;
        idle();

        // beq taken, predicted not taken
        exec(1, 0, 3'b000, 4'b0001, 32'h100, 32'h80, 0);
        chk("beq_rv", {31'd0, redirect_valid}, 32'd1);
        chk("beq_flush", {31'd0, flush}, 32'd1);
        chk("beq_rpc", redirect_pc, 32'h80);
        ent("beq_bht", 0, 2'b10);
        chk("beq_br", br_count, 32'd1);
        chk("beq_mis", mispred_count, 32'd1);
        idle();
        chk("beq_rv_n2", {31'd0, redirect_valid}, 32'd0);
        chk("beq_rpc_hold", redirect_pc, 32'h80);

        // bltu not taken (c=1), fall-through wraps to 0
        exec(1, 0, 3'b110, 4'b0100, 32'hFFFF_FFFC, 32'h40, 1);
        chk("bltu_rv", {31'd0, redirect_valid}, 32'd1);
        chk("bltu_rpc", redirect_pc, 32'h0);
        ent("bltu_bht", 63, 2'b00);
        chk("bltu_mis", mispred_count, 32'd2);
        idle();

        // blt taken (n^v=1) correctly predicted
        exec(1, 0, 3'b100, 4'b1000, 32'h204, 32'h300, 1);
        chk("blt_rv", {31'd0, redirect_valid}, 32'd0);
        chk("blt_mis", mispred_count, 32'd2);
        chk("blt_br", br_count, 32'd3);
        ent("blt_bht", 1, 2'b10);

        // back-to-back mispredicts: second is on the wrong path
        exec(1, 0, 3'b000, 4'b0000, 32'h208, 32'h400, 1);
        chk("b2b1_rv", {31'd0, redirect_valid}, 32'd1);
        chk("b2b1_rpc", redirect_pc, 32'h20C);
        ent("b2b1_bht", 2, 2'b00);
        exec(1, 0, 3'b001, 4'b0000, 32'h20C, 32'h500, 0);
        chk("b2b2_rv", {31'd0, redirect_valid}, 32'd0);
        chk("b2b2_rpc", redirect_pc, 32'h20C);
        ent("b2b2_bht", 3, 2'b01);
        chk("b2b2_br", br_count, 32'd4);
        chk("b2b2_mis", mispred_count, 32'd3);

        // five taken beq on the same PC; read collides with update
        pc_if = 32'h110;
        present(1, 0, 3'b000, 4'b0001, 32'h110, 32'h10, 1);
        #1;
        chk("sat_pre_pred", {31'd0, pred_taken_if}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            ent($sformatf("sat_bht%0d", k), 4, (k >= 2) ? 2'b11 : 2'b10);
            chk($sformatf("sat_pred%0d", k), {31'd0, pred_taken_if}, 32'd1);
        end
        valid_ex = 1'b0;
        chk("sat_br", br_count, 32'd9);
        chk("sat_mis", mispred_count, 32'd3);

        // funct3=010 is not a branch
        exec(1, 0, 3'b010, 4'b0001, 32'h120, 32'h600, 0);
        chk("f010_rv", {31'd0, redirect_valid}, 32'd0);
        chk("f010_br", br_count, 32'd9);
        chk("f010_mis", mispred_count, 32'd3);
        ent("f010_bht", 8, 2'b01);

        // branch+jump together behaves as jump
        exec(1, 1, 3'b000, 4'b0001, 32'h130, 32'h1000, 0);
        chk("jal_rv", {31'd0, redirect_valid}, 32'd1);
        chk("jal_rpc", redirect_pc, 32'h1000);
        chk("jal_mis", mispred_count, 32'd4);
        chk("jal_br", br_count, 32'd9);
        ent("jal_bht", 12, 2'b01);
        idle();

        // bge taken, mispredicted, stalled three cycles
        present(1, 0, 3'b101, 4'b0000, 32'h140, 32'h2000, 0);
        stall_ex = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall_rv%0d", k), {31'd0, redirect_valid}, 32'd0);
            chk($sformatf("stall_br%0d", k), br_count, 32'd9);
            ent($sformatf("stall_bht%0d", k), 16, 2'b01);
        end
        stall_ex = 1'b0;
        tick();
        valid_ex = 1'b0;
        chk("unstall_rv", {31'd0, redirect_valid}, 32'd1);
        chk("unstall_rpc", redirect_pc, 32'h2000);
        chk("unstall_br", br_count, 32'd10);
        chk("unstall_mis", mispred_count, 32'd5);
        ent("unstall_bht", 16, 2'b10);

        // asynchronous reset while flush is high
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_flush", {31'd0, flush}, 32'd0);
        chk("arst_rv", {31'd0, redirect_valid}, 32'd0);
        chk("arst_rpc", redirect_pc, 32'd0);
        chk("arst_mis", mispred_count, 32'd0);
        ent("arst_bht0", 0, 2'b01);
        ent("arst_bht4", 4, 2'b01);
        ent("arst_bht16", 16, 2'b01);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        chk("arst_post_rv", {31'd0, redirect_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
